// File: rtl/mux_2to1_arb.sv
// mux_2to1_arb: two-requester data mux with a registered round-robin style
// arbiter. A requester may keep the grant for up to MAX_HOLD transfers while
// the other one waits, then the grant is handed over.
//
// Optional build macro: MUX_ARB_LOCK_EN adds a 'lock' input that, while high,
// keeps the current owner from being preempted at the hold limit.
//
// state  | meaning
// IDLE   | no grant; sel keeps its last value
// GRANT0 | requester 0 owns the output (gnt0=1, sel=0)
// GRANT1 | requester 1 owns the output (gnt1=1, sel=1)
module mux_2to1_arb #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic [WIDTH-1:0] mux_out,
  output logic             out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_cnt_nxt;
  logic       last_served, last_served_nxt;
  logic       sel_q, sel_nxt;
  logic       lock_eff;
  logic       own_req, oth_req;
  logic       xfer;
  state_t     oth_state;

`ifdef MUX_ARB_LOCK_EN
  assign lock_eff = lock;
`else
  assign lock_eff = 1'b0;
`endif

  assign gnt0      = (state == GRANT0);
  assign gnt1      = (state == GRANT1);
  assign sel       = sel_q;
  assign mux_out   = sel_q ? in1 : in0;
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign xfer      = out_valid & out_ready;

  // Requests seen from the point of view of the current owner.
  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    oth_state = IDLE;
    if (state == GRANT0) begin
      own_req   = req0;
      oth_req   = req1;
      oth_state = GRANT1;
    end else if (state == GRANT1) begin
      own_req   = req1;
      oth_req   = req0;
      oth_state = GRANT0;
    end
  end

  // Next-state, hold counter and last-served/select update.
  always_comb begin
    state_nxt       = state;
    hold_cnt_nxt    = hold_cnt;
    last_served_nxt = last_served;
    sel_nxt         = sel_q;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = last_served ? GRANT0 : GRANT1;
        else if (req0)
          state_nxt = GRANT0;
        else if (req1)
          state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        // A dropped request releases immediately; there is nothing to stall.
        if (!own_req) begin
          state_nxt = oth_req ? oth_state : IDLE;
        end else if (xfer) begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt_nxt = 4'd0;
            if (oth_req && !lock_eff)
              state_nxt = oth_state;
          end else begin
            hold_cnt_nxt = hold_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) begin
      hold_cnt_nxt = 4'd0;
      if (state_nxt == GRANT0) begin
        last_served_nxt = 1'b0;
        sel_nxt         = 1'b0;
      end else if (state_nxt == GRANT1) begin
        last_served_nxt = 1'b1;
        sel_nxt         = 1'b1;
      end
    end
  end

  // State register; last_served resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= 4'd0;
      last_served <= 1'b1;
      sel_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      last_served <= last_served_nxt;
      sel_q       <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_mux_2to1_arb.sv
// Testbench for mux_2to1_arb: directed scenarios followed by random traffic,
// all checked cycle by cycle against an ownership model of the arbiter.
module tb_mux_2to1_arb;

  localparam int W        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst, req0, req1, out_ready, lock_in;
  logic [W-1:0] in0, in1;
  logic         gnt0, gnt1, sel, out_valid;
  logic [W-1:0] mux_out;

  int errors = 0;
  int checks = 0;

  // Model: owner (-1 none, 0, 1), transfers made in current hold window,
  // who was served last, and the current select.
  int m_own  = -1;
  int m_cnt  = 0;
  int m_last = 1;
  bit m_sel  = 1'b0;
  bit armed  = 1'b0;

  mux_2to1_arb #(.WIDTH(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .in0(in0), .in1(in1),
    .out_ready(out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock(lock_in),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .mux_out(mux_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, check combinational outputs, advance model and
  // DUT through the rising edge, then check registered outputs.
  task automatic cyc(input bit r0, input bit r1, input logic [W-1:0] d0,
                     input logic [W-1:0] d1, input bit rdy, input bit rs, input bit lk);
    int own, cnt, last;
    bit s, mine, oth, lk_eff;
    req0 = r0; req1 = r1; in0 = d0; in1 = d1; out_ready = rdy; rst = rs; lock_in = lk;
    #1;
    if (armed) begin
      chk("out_valid", {31'd0, out_valid}, ((m_own == 0 && r0) || (m_own == 1 && r1)) ? 1 : 0);
      chk("mux_out", {{(32-W){1'b0}}, mux_out}, {{(32-W){1'b0}}, (m_sel ? d1 : d0)});
    end
`ifdef MUX_ARB_LOCK_EN
    lk_eff = lk;
`else
    lk_eff = 1'b0;
`endif
    own = m_own; cnt = m_cnt; last = m_last; s = m_sel;
    if (rs) begin
      own = -1; cnt = 0; last = 1; s = 1'b0;
    end else begin
      if (m_own < 0) begin
        if (r0 && r1) own = (m_last == 1) ? 0 : 1;
        else if (r0)  own = 0;
        else if (r1)  own = 1;
      end else begin
        mine = (m_own == 0) ? r0 : r1;
        oth  = (m_own == 0) ? r1 : r0;
        if (!mine) begin
          own = oth ? 1 - m_own : -1;
        end else if (rdy) begin
          if (m_cnt == MAX_HOLD - 1) begin
            cnt = 0;
            if (oth && !lk_eff) own = 1 - m_own;
          end else begin
            cnt = m_cnt + 1;
          end
        end
      end
      if (own != m_own) begin
        cnt = 0;
        if (own >= 0) begin
          last = own;
          s    = (own == 1);
        end
      end
    end
    @(posedge clk);
    #1;
    m_own = own; m_cnt = cnt; m_last = last; m_sel = s;
    armed = 1'b1;
    chk("gnt0", {31'd0, gnt0}, (m_own == 0) ? 1 : 0);
    chk("gnt1", {31'd0, gnt1}, (m_own == 1) ? 1 : 0);
    chk("sel",  {31'd0, sel},  {31'd0, m_sel});
  endtask

  initial begin
    // Reset held for two cycles, then released.
    cyc(0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(0, 0, 4'h0, 4'h0, 1, 0, 0);
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_sel",  {31'd0, sel}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);

    // Tie after reset: requester 0 first, four transfers, then requester 1.
    cyc(1, 1, 4'h3, 4'hC, 1, 0, 0);
    chk("tie_first_gnt0", {31'd0, gnt0}, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 4'(i), 4'hC, 1, 0, 0);
    chk("tie_hold_gnt0", {31'd0, gnt0}, 1);
    cyc(1, 1, 4'h5, 4'hC, 1, 0, 0);
    chk("tie_handover_gnt1", {31'd0, gnt1}, 1);
    chk("tie_handover_sel", {31'd0, sel}, 1);

    // Single requester 1, then release; sel holds in IDLE.
    cyc(0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(0, 1, 4'h0, 4'h1, 1, 0, 0);
    chk("r1_only_gnt1", {31'd0, gnt1}, 1);
    chk("r1_only_mux", {28'd0, mux_out}, 1);
    cyc(0, 0, 4'h0, 4'h1, 1, 0, 0);
    chk("r1_drop_idle", {30'd0, gnt1, gnt0}, 0);
    chk("r1_drop_sel", {31'd0, sel}, 1);

    // Stall in GRANT0: two transfers, five stalled cycles, then the rest.
    cyc(0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 4'h7, 4'h8, 0, 0, 0);
    chk("stall_gnt0", {31'd0, gnt0}, 1);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);
    chk("stall_resume_gnt0", {31'd0, gnt0}, 1);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);
    chk("stall_handover_gnt1", {31'd0, gnt1}, 1);

    // Reset during GRANT1 with downstream ready.
    cyc(1, 1, 4'h7, 4'h8, 1, 1, 0);
    chk("rst_abort_gnt1", {31'd0, gnt1}, 0);
    chk("rst_abort_sel", {31'd0, sel}, 0);
    cyc(1, 1, 4'h7, 4'h8, 1, 0, 0);

`ifdef MUX_ARB_LOCK_EN
    // Lock keeps requester 0 past the hold limit; unlock hands over at the next limit.
    cyc(0, 0, 4'h0, 4'h0, 1, 1, 0);
    cyc(1, 1, 4'h2, 4'h9, 1, 0, 1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 4'h2, 4'h9, 1, 0, 1);
    chk("lock_gnt0", {31'd0, gnt0}, 1);
    cyc(1, 1, 4'h2, 4'h9, 1, 0, 0);
    cyc(1, 1, 4'h2, 4'h9, 1, 0, 0);
    chk("unlock_gnt1", {31'd0, gnt1}, 1);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          W'($urandom), W'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
